// File: rtl/mem_io_responder.sv
// Memory-side responder for the 16-bit multicycle processor bus: word RAM, LED register,
// synchronized switches and a down-counting interval timer. Read data is registered one clock after ADDR.
module mem_io_responder #(
  parameter int RAM_AW   = 8,
  parameter int TICK_DIV = 1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic        TimerIrq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [15:0] ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;

  logic [9:0]  sw_meta, sw_sync;
  logic [15:0] load, count;
  logic        enable, autoreload, expired;
  logic [PW-1:0] presc;

  logic sel_ram, sel_led, sel_sw, sel_tmr;
  logic wr_led, wr_load, wr_ctrl, wr_status;
  logic tick, expiry;
  logic [15:0] rd_data;
  logic unused_addr;

  assign ram_idx     = ADDR[RAM_AW-1:0];
  assign unused_addr = ^ADDR[11:RAM_AW];

  assign sel_ram = (ADDR[15:12] == 4'h0);
  assign sel_led = (ADDR[15:12] == 4'h1);
  assign sel_sw  = (ADDR[15:12] == 4'h3);
  assign sel_tmr = (ADDR[15:12] == 4'h4);

  assign wr_led    = W && sel_led;
  assign wr_load   = W && sel_tmr && (ADDR[1:0] == 2'd0);
  assign wr_ctrl   = W && sel_tmr && (ADDR[1:0] == 2'd1);
  assign wr_status = W && sel_tmr && (ADDR[1:0] == 2'd3);

  // A LOAD write on a tick edge overrides the tick, so it cannot expire the old count.
  assign tick   = enable && (presc == PRESC_LAST);
  assign expiry = tick && (count == 16'd1) && !wr_load;

  assign TimerIrq = expired;

  // RAM has no reset; a write presented on a reset edge is dropped.
  always_ff @(posedge Clock) begin
    if (Resetn && W && sel_ram) ram[ram_idx] <= DOUT;
  end

  always_comb begin
    rd_data = 16'h0000;
    if (sel_ram)      rd_data = ram[ram_idx];
    else if (sel_led) rd_data = {6'b0, LEDR};
    else if (sel_sw)  rd_data = {6'b0, sw_sync};
    else if (sel_tmr) begin
      case (ADDR[1:0])
        2'd0:    rd_data = load;
        2'd1:    rd_data = {14'b0, autoreload, enable};
        2'd2:    rd_data = count;
        default: rd_data = {15'b0, expired};
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      DIN     <= 16'h0000;
      LEDR    <= 10'h000;
      sw_meta <= 10'h000;
      sw_sync <= 10'h000;
    end else begin
      DIN     <= rd_data;
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (wr_led) LEDR <= DOUT[9:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      load       <= 16'h0000;
      count      <= 16'h0000;
      enable     <= 1'b0;
      autoreload <= 1'b0;
      expired    <= 1'b0;
      presc      <= '0;
    end else begin
      if (wr_load || (wr_ctrl && !DOUT[0]) || tick) presc <= '0;
      else if (enable)                             presc <= presc + 1'b1;

      if (wr_load) begin
        load  <= DOUT;
        count <= DOUT;
      end else if (tick) begin
        if (count > 16'd1)       count <= count - 16'd1;
        else if (count == 16'd1) count <= autoreload ? load : 16'h0000;
      end

      if (wr_ctrl) begin
        enable     <= DOUT[0];
        autoreload <= DOUT[1];
      end else if (expiry && !autoreload) begin
        enable <= 1'b0;
      end

      // Expiry beats a simultaneous clear.
      if (expiry)                      expired <= 1'b1;
      else if (wr_status && DOUT[0])   expired <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder (RAM_AW=8, TICK_DIV=1); expected values are hand-computed.
module tb_mem_io_responder;

  logic        Clock;
  logic        Resetn;
  logic [15:0] ADDR, DOUT, DIN;
  logic        W;
  logic [9:0]  SW, LEDR;
  logic        TimerIrq;

  int n_checks = 0;
  int n_pass   = 0;

  mem_io_responder #(.RAM_AW(8), .TICK_DIV(1)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
    .DIN(DIN), .SW(SW), .LEDR(LEDR), .TimerIrq(TimerIrq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // One clock: inputs set before the call are captured; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; DOUT = d; W = 1'b1;
    step();
    W = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    ADDR = a; W = 1'b0;
    step();
    check_eq(tag, DIN, exp);
  endtask

  initial begin
    Resetn = 1'b0; ADDR = 16'h0000; DOUT = 16'h0000; W = 1'b0; SW = 10'h000;
    step(); step();
    Resetn = 1'b1;
    check_eq("rst_din", DIN, 16'h0000);
    check_eq("rst_ledr", {6'b0, LEDR}, 16'h0000);
    check_eq("rst_irq", {15'b0, TimerIrq}, 16'h0000);
    rd("rst_count", 16'h4002, 16'h0000);

    // RAM write/readback and aliasing
    wr(16'h0005, 16'hBEEF);
    rd("ram_rd", 16'h0005, 16'hBEEF);
    rd("ram_alias", 16'h0105, 16'hBEEF);

    // Read-first collision
    wr(16'h0003, 16'h1111);
    ADDR = 16'h0003; DOUT = 16'h2222; W = 1'b1;
    step();
    check_eq("coll_old", DIN, 16'h1111);
    W = 1'b0;
    step();
    check_eq("coll_new", DIN, 16'h2222);

    // LEDs
    wr(16'h1000, 16'hFFFF);
    check_eq("ledr_val", {6'b0, LEDR}, 16'h03FF);
    rd("ledr_rd", 16'h1000, 16'h03FF);

    // Switch synchronizer: visible on DIN at the third edge
    ADDR = 16'h3000; SW = 10'h155;
    step();
    step();
    check_eq("sw_edge2", DIN, 16'h0000);
    step();
    check_eq("sw_edge3", DIN, 16'h0155);

    // Unmapped region, including an ignored write
    wr(16'h2000, 16'h1234);
    rd("unmapped", 16'h2000, 16'h0000);

    // One-shot timer: first tick is at the edge after CTRL is written
    wr(16'h4000, 16'h0003);
    wr(16'h4001, 16'h0001);
    ADDR = 16'h4002;
    step(); check_eq("os_cnt3", DIN, 16'h0003);
    check_eq("os_irq_lo", {15'b0, TimerIrq}, 16'h0000);
    step(); check_eq("os_cnt2", DIN, 16'h0002);
    step(); check_eq("os_cnt1", DIN, 16'h0001);
    check_eq("os_irq_hi", {15'b0, TimerIrq}, 16'h0001);
    step(); check_eq("os_cnt0", DIN, 16'h0000);
    rd("os_ctrl", 16'h4001, 16'h0000);
    rd("os_status", 16'h4003, 16'h0001);
    rd("os_cnt_hold", 16'h4002, 16'h0000);
    wr(16'h4003, 16'h0000);
    check_eq("os_clr0_noeff", {15'b0, TimerIrq}, 16'h0001);
    wr(16'h4003, 16'h0001);
    check_eq("os_clr", {15'b0, TimerIrq}, 16'h0000);
    wr(16'h4002, 16'h0005);
    rd("cnt_ro", 16'h4002, 16'h0000);

    // Autoreload LOAD=2: expiries two clocks apart; clear on an expiry edge loses
    wr(16'h4000, 16'h0002);
    wr(16'h4001, 16'h0003);
    ADDR = 16'h4001;
    step(); check_eq("ar_irq0", {15'b0, TimerIrq}, 16'h0000);
    step(); check_eq("ar_irq1", {15'b0, TimerIrq}, 16'h0001);
    wr(16'h4003, 16'h0001);
    check_eq("ar_clr", {15'b0, TimerIrq}, 16'h0000);
    wr(16'h4003, 16'h0001);
    check_eq("ar_setwins", {15'b0, TimerIrq}, 16'h0001);
    rd("ar_ctrl", 16'h4001, 16'h0003);
    wr(16'h4001, 16'h0000);

    // Reset mid-run
    wr(16'h0010, 16'hA5A5);
    wr(16'h1000, 16'h02AA);
    wr(16'h4000, 16'h0040);
    wr(16'h4001, 16'h0001);
    rd("mr_cnt_run", 16'h4002, 16'h0040);
    rd("mr_cnt_dec", 16'h4002, 16'h003F);
    check_eq("mr_irq_pre", {15'b0, TimerIrq}, 16'h0001);
    ADDR = 16'h0010; DOUT = 16'hDEAD; W = 1'b1; Resetn = 1'b0;
    step();
    Resetn = 1'b1; W = 1'b0;
    check_eq("mr_din", DIN, 16'h0000);
    check_eq("mr_ledr", {6'b0, LEDR}, 16'h0000);
    check_eq("mr_irq", {15'b0, TimerIrq}, 16'h0000);
    rd("mr_count", 16'h4002, 16'h0000);
    rd("mr_ctrl", 16'h4001, 16'h0000);
    rd("mr_count2", 16'h4002, 16'h0000);
    rd("mr_ram_keep", 16'h0010, 16'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
